nios_debug_vjtag_master: RTL and testbench

//  Scan-chain initiator for the Nios II on-chip debug slave's virtual-JTAG port.

---
 rtl/nios_debug_vjtag_master_if.sv | 24 ++
 rtl/nios_debug_vjtag_master.sv | 142 ++++++++++++++
 tb/tb_nios_debug_vjtag_master.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_debug_vjtag_master_if.sv
// Command/response bus for the virtual-JTAG scan initiator.
// The initiator takes the slave modport; whoever issues scans takes the master modport.
interface nios_debug_vjtag_master_if #(
    parameter int SR_W = 38,
    parameter int IR_W = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [SR_W-1:0] cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [SR_W-1:0] rsp_data;

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/nios_debug_vjtag_master.sv
// Plays one update-IR / capture-DR / shift-DR / update-DR / run-test-idle sequence on the
// vji_* nets of the Nios II debug slave and returns the word shifted out of vji_tdo.
module nios_debug_vjtag_master #(
    parameter int SR_W    = 38,
    parameter int IR_W    = 2,
    parameter int TCK_DIV = 2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    nios_debug_vjtag_master_if.slave            bus,
    input  logic                                abort,
    output logic                                vji_tck,
    output logic                                vji_tdi,
    input  logic                                vji_tdo,
    output logic [IR_W-1:0]                     vji_ir_in,
    output logic                                vji_uir,
    output logic                                vji_cdr,
    output logic                                vji_sdr,
    output logic                                vji_udr,
    output logic                                vji_rti,
    output logic                                busy
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_UDR  = 3'd4;
    localparam logic [2:0] S_RTI  = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = $clog2(SR_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_W);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tck;
    logic             r_tdi;
    logic [IR_W-1:0]  r_ir;
    logic [BIT_W-1:0] r_bitcnt;
    logic [SR_W-1:0]  r_shreg;

    logic w_active;
    logic w_wrap;
    logic w_rise;
    logic w_fall;
    logic w_accept;

    assign w_active = (r_state >= S_UIR) && (r_state <= S_RTI);
    assign w_wrap   = w_active && (r_cnt == CNT_MAX);
    assign w_rise   = w_wrap && !r_tck;
    assign w_fall   = w_wrap && r_tck;
    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_tck    <= 1'b0;
            r_tdi    <= 1'b0;
            r_ir     <= '0;
            r_bitcnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_state  <= S_UIR;
                        r_ir     <= bus.cmd_ir;
                        r_bitcnt <= '0;
                        r_cnt    <= '0;
                        r_tck    <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) r_state <= S_IDLE;
                end
                S_UIR, S_CDR, S_SDR, S_UDR, S_RTI: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_tck   <= 1'b0;
                        r_tdi   <= 1'b0;
                    end else begin
                        if (w_wrap) begin
                            r_cnt <= '0;
                            r_tck <= ~r_tck;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_rise && (r_state == S_SDR)) r_bitcnt <= r_bitcnt + BIT_W'(1);
                        // tdi is relaunched on falls only, so it is stable across a whole tck period
                        if (w_fall) begin
                            case (r_state)
                                S_UIR: r_state <= S_CDR;
                                S_CDR: begin
                                    r_state <= S_SDR;
                                    r_tdi   <= r_shreg[0];
                                end
                                S_SDR: begin
                                    if (r_bitcnt == BIT_LAST) begin
                                        r_state <= S_UDR;
                                        r_tdi   <= 1'b0;
                                    end else begin
                                        r_tdi   <= r_shreg[0];
                                    end
                                end
                                S_UDR:   r_state <= S_RTI;
                                S_RTI:   r_state <= S_RESP;
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shift register: loads on accept, captures vji_tdo on each rise in shift-DR
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shreg <= bus.cmd_data;
        end else if (w_rise && (r_state == S_SDR) && !abort) begin
            r_shreg <= {vji_tdo, r_shreg[SR_W-1:1]};
        end
    end

    assign bus.cmd_ready = reset_n && (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_data  = (r_state == S_RESP) ? r_shreg : '0;

    assign vji_tck   = r_tck;
    assign vji_tdi   = r_tdi;
    assign vji_ir_in = r_ir;
    assign vji_uir   = (r_state == S_UIR);
    assign vji_cdr   = (r_state == S_CDR);
    assign vji_sdr   = (r_state == S_SDR);
    assign vji_udr   = (r_state == S_UDR);
    assign vji_rti   = (r_state == S_RTI);
    assign busy      = w_active;
endmodule

// File: tb/tb_nios_debug_vjtag_master.sv
// Bench for nios_debug_vjtag_master: one instance at TCK_DIV=2 and one at TCK_DIV=1,
// driven through a shared command path and checked against a period-level model.
module tb_nios_debug_vjtag_master;
    localparam int SR_W = 38;
    localparam int IR_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit              sel = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            rsp_ready = 1'b0;
    logic            abort = 1'b0;
    logic [IR_W-1:0] cmd_ir = '0;
    logic [SR_W-1:0] cmd_data = '0;
    logic            vji_tdo;

    int              tdo_mode = 0;
    logic [SR_W-1:0] tdo_word = '0;
    int              rise_cnt = 0;
    int              sdr_per = 0;
    int              per_cnt [5];
    logic [SR_W-1:0] exp_data = '0;
    logic [IR_W-1:0] exp_ir = '0;

    nios_debug_vjtag_master_if #(.SR_W(SR_W), .IR_W(IR_W)) bus2 ();
    nios_debug_vjtag_master_if #(.SR_W(SR_W), .IR_W(IR_W)) bus1 ();

    wire            tck2, tdi2, busy2, tck1, tdi1, busy1;
    wire [4:0]      strb2, strb1;
    wire [IR_W-1:0] ir2, ir1;

    assign bus2.cmd_valid = cmd_valid & ~sel;
    assign bus1.cmd_valid = cmd_valid & sel;
    assign bus2.rsp_ready = rsp_ready & ~sel;
    assign bus1.rsp_ready = rsp_ready & sel;
    assign bus2.cmd_ir    = cmd_ir;
    assign bus1.cmd_ir    = cmd_ir;
    assign bus2.cmd_data  = cmd_data;
    assign bus1.cmd_data  = cmd_data;

    nios_debug_vjtag_master #(.SR_W(SR_W), .IR_W(IR_W), .TCK_DIV(2)) u_dut2 (
        .clk(clk), .reset_n(rst_n), .bus(bus2.slave), .abort(abort & ~sel),
        .vji_tck(tck2), .vji_tdi(tdi2), .vji_tdo(vji_tdo), .vji_ir_in(ir2),
        .vji_uir(strb2[0]), .vji_cdr(strb2[1]), .vji_sdr(strb2[2]),
        .vji_udr(strb2[3]), .vji_rti(strb2[4]), .busy(busy2)
    );

    nios_debug_vjtag_master #(.SR_W(SR_W), .IR_W(IR_W), .TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .bus(bus1.slave), .abort(abort & sel),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(vji_tdo), .vji_ir_in(ir1),
        .vji_uir(strb1[0]), .vji_cdr(strb1[1]), .vji_sdr(strb1[2]),
        .vji_udr(strb1[3]), .vji_rti(strb1[4]), .busy(busy1)
    );

    wire            m_ready     = sel ? bus1.cmd_ready : bus2.cmd_ready;
    wire            m_rsp_valid = sel ? bus1.rsp_valid : bus2.rsp_valid;
    wire [SR_W-1:0] m_rsp_data  = sel ? bus1.rsp_data  : bus2.rsp_data;
    wire            m_tck       = sel ? tck1 : tck2;
    wire            m_tdi       = sel ? tdi1 : tdi2;
    wire            m_busy      = sel ? busy1 : busy2;
    wire [4:0]      m_strb      = sel ? strb1 : strb2;
    wire [IR_W-1:0] m_ir        = sel ? ir1 : ir2;

    // Slave model: loopback, stuck-at-1, or a random word presented one bit per tck rise
    assign vji_tdo = (tdo_mode == 0) ? m_tdi :
                     (tdo_mode == 1) ? 1'b1 :
                     ((rise_cnt < SR_W) ? tdo_word[rise_cnt] : 1'b0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor: sampled on the falling clk edge, away from the active edge
    initial begin
        logic       p_tck, p_busy, p_abort;
        logic [4:0] p_strb;
        int         len;
        p_tck = 1'b0; p_busy = 1'b0; p_abort = 1'b0; p_strb = '0; len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_tck = 1'b0; p_busy = 1'b0; p_abort = 1'b0; p_strb = '0;
                continue;
            end
            if (m_busy && !p_busy) begin
                rise_cnt = 0;
                sdr_per  = 0;
                for (int k = 0; k < 5; k++) per_cnt[k] = 0;
                len = 1;
            end else if (m_busy && p_busy) begin
                if (m_tck != p_tck) begin
                    chk("tck_half_period", len, sel ? 1 : 2);
                    len = 1;
                end else begin
                    len++;
                end
            end
            if (m_tck && !p_tck && m_strb[2]) rise_cnt++;
            if (!m_tck && p_tck) begin
                for (int k = 0; k < 5; k++) if (p_strb[k]) per_cnt[k]++;
                if (p_strb[2]) sdr_per++;
            end
            chk("strobe_onehot", m_busy ? $onehot(m_strb) : (m_strb == 5'd0), 1);
            if ((m_strb != p_strb) && p_busy && !p_abort)
                chk("strobe_only_at_fall", {p_tck, m_tck}, 2'b10);
            if (m_strb[2]) chk("tdi_shift", m_tdi, exp_data[sdr_per]);
            else           chk("tdi_idle", m_tdi, 0);
            if (m_busy) chk("ir_in_during_scan", m_ir, exp_ir);
            p_tck = m_tck; p_busy = m_busy; p_abort = abort; p_strb = m_strb;
        end
    end

    task automatic accept(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] data,
                          input int mode, input bit expect_no_wait);
        int n;
        cmd_ir = ir; cmd_data = data; exp_ir = ir; exp_data = data; tdo_mode = mode;
        cmd_valid = 1'b1;
        n = 0;
        while (!m_ready && n < 50) begin step; n++; end
        if (expect_no_wait) chk("accept_without_wait", n, 0);
        step;
        cmd_valid = 1'b0;
        chk("busy_after_accept", m_busy, 1);
        chk("uir_after_accept", m_strb, 5'b00001);
        chk("tck_low_after_accept", m_tck, 0);
        chk("ready_low_after_accept", m_ready, 0);
    endtask

    task automatic xact(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] data,
                        input int mode, input int rdly, input bit expect_no_wait);
        int n;
        logic [SR_W-1:0] exp_rsp;
        exp_rsp = (mode == 0) ? data : (mode == 1) ? {SR_W{1'b1}} : tdo_word;
        accept(ir, data, mode, expect_no_wait);
        n = 0;
        while (!m_rsp_valid && n < 1000) begin step; n++; end
        chk("latency", n, (SR_W + 4) * 2 * (sel ? 1 : 2));
        chk("rsp_data", m_rsp_data, exp_rsp);
        for (int i = 0; i < rdly; i++) begin
            step;
            chk("hold_rsp_valid", m_rsp_valid, 1);
            chk("hold_rsp_data", m_rsp_data, exp_rsp);
            chk("hold_cmd_ready", m_ready, 0);
            chk("hold_tck", m_tck, 0);
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        chk("post_handshake_valid", m_rsp_valid, 0);
        chk("post_handshake_ready", m_ready, 1);
        chk("ir_held_after_rsp", m_ir, ir);
        for (int k = 0; k < 5; k++) chk("periods_per_strobe", per_cnt[k], (k == 2) ? SR_W : 1);
    endtask

    initial begin
        int n;
        bit seen;
        logic [SR_W-1:0] rnd;

        // Reset state
        #12;
        chk("reset_outputs_dut2", {bus2.cmd_ready, bus2.rsp_valid, tck2, tdi2, strb2, busy2, ir2}, 0);
        chk("reset_outputs_dut1", {bus1.cmd_ready, bus1.rsp_valid, tck1, tdi1, strb1, busy1, ir1}, 0);
        chk("reset_rsp_data", bus2.rsp_data, 0);
        step;
        rst_n = 1'b1;
        step;
        chk("ready_after_reset", m_ready, 1);

        // Loopback, stuck-at-1, long response stall, back-to-back accept
        xact(2'b01, 38'h2A_AAAA_AAAA, 0, 0, 1'b1);
        xact(2'b10, 38'h00_0000_0001, 1, 3, 1'b1);
        tdo_word = {$urandom, $urandom};
        xact(2'b11, {$urandom, $urandom}, 2, 10, 1'b1);
        xact(2'b00, {$urandom, $urandom}, 0, 0, 1'b1);

        for (int t = 0; t < 3; t++) begin
            tdo_word = {$urandom, $urandom};
            rnd = {$urandom, $urandom};
            xact(IR_W'($urandom_range(0, 3)), rnd, $urandom_range(0, 2), $urandom_range(0, 4), 1'b1);
        end

        // Abort during shift-DR bit 20
        accept(2'b10, {$urandom, $urandom}, 0, 1'b1);
        n = 0;
        while (!(m_strb[2] && rise_cnt == 20) && n < 1000) begin step; n++; end
        chk("reached_sdr_bit20", rise_cnt, 20);
        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("abort_tck", m_tck, 0);
        chk("abort_strobes", m_strb, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_tdi", m_tdi, 0);
        chk("abort_ready", m_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step;
            if (m_rsp_valid) seen = 1'b1;
        end
        chk("abort_no_response", seen, 0);
        xact(2'b01, {$urandom, $urandom}, 0, 1, 1'b1);

        // Asynchronous reset mid-scan
        accept(2'b11, {$urandom, $urandom}, 0, 1'b1);
        n = 0;
        while (!(m_strb[2] && rise_cnt == 10) && n < 1000) begin step; n++; end
        chk("reached_sdr_bit10", rise_cnt, 10);
        rst_n = 1'b0;
        #2;
        chk("async_reset_outputs", {bus2.cmd_ready, bus2.rsp_valid, tck2, tdi2, strb2, busy2, ir2}, 0);
        chk("async_reset_rsp_data", bus2.rsp_data, 0);
        step;
        step;
        rst_n = 1'b1;
        step;

        // Fast tck instance
        sel = 1'b1;
        step;
        xact(2'b01, {$urandom, $urandom}, 0, 0, 1'b1);
        tdo_word = {$urandom, $urandom};
        xact(2'b10, {$urandom, $urandom}, 2, 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
